// File: rtl/iter_alu_if.sv
// Handshake and result bus between the calculator control FSM (master)
// and the iterative ALU (slave).
interface iter_alu_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       regoutA;
    logic [WIDTH-1:0]       regoutB;
    logic [1:0]             ALUFuncSel;
    logic                   ready;
    logic                   done;
    logic [2*WIDTH-1:0]     aluout;
    logic                   div0;

    modport master (
        output start, regoutA, regoutB, ALUFuncSel,
        input  ready, done, aluout, div0
    );

    modport slave (
        input  start, regoutA, regoutB, ALUFuncSel,
        output ready, done, aluout, div0
    );
endinterface

// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle add/sub, shift-add multiply and restoring
// divide at one bit per clock, launched with a start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; ready=1
// RUN   | mul/div iterating, WIDTH cycles; ready=0, start ignored
// DONE  | result just written; done=1 for this single cycle; ready=1
module iter_alu #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    iter_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic                 is_div;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     shreg;      // multiplier (mul) or dividend/quotient (div)
    logic [WIDTH-1:0]     rem;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   aluout_q;
    logic                 done_q;
    logic                 ready_q;
    logic                 div0_q;

    logic                 accept;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     rem_nxt;
    logic [WIDTH-1:0]     quo_nxt;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   addsub_res;

    assign bus.aluout = aluout_q;
    assign bus.done   = done_q;
    assign bus.ready  = ready_q;
    assign bus.div0   = div0_q;

    assign accept = bus.start & ready_q;

    // Next-iteration datapath values for mul/div and the single-cycle add/sub result.
    always_comb begin
        acc_nxt   = shreg[0] ? (acc + mcand) : acc;
        div_shift = {rem, shreg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, divisor});
        // When div_ge holds the difference is below 2^WIDTH, so WIDTH bits suffice.
        rem_nxt   = div_ge ? (div_shift[WIDTH-1:0] - divisor) : div_shift[WIDTH-1:0];
        quo_nxt   = {shreg[WIDTH-2:0], div_ge};
        sum       = {1'b0, bus.regoutA} + {1'b0, bus.regoutB};
        diff      = {1'b0, bus.regoutA} - {1'b0, bus.regoutB};
        addsub_res = bus.ALUFuncSel[0] ? {{(WIDTH-1){1'b0}}, sum}
                                       : {{(WIDTH-1){diff[WIDTH]}}, diff};
    end

    // Control FSM, iteration registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            is_div   <= 1'b0;
            divisor  <= '0;
            shreg    <= '0;
            rem      <= '0;
            mcand    <= '0;
            acc      <= '0;
            cnt      <= '0;
            aluout_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            div0_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (bus.ALUFuncSel[1]) begin
                            aluout_q <= addsub_res;
                            div0_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            is_div  <= bus.ALUFuncSel[0];
                            divisor <= bus.regoutB;
                            shreg   <= bus.ALUFuncSel[0] ? bus.regoutA : bus.regoutB;
                            mcand   <= {{WIDTH{1'b0}}, bus.regoutA};
                            acc     <= '0;
                            rem     <= '0;
                            cnt     <= CW'(WIDTH - 1);
                            ready_q <= 1'b0;
                            state   <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        rem   <= rem_nxt;
                        shreg <= quo_nxt;
                    end else begin
                        acc   <= acc_nxt;
                        mcand <= mcand << 1;
                        shreg <= shreg >> 1;
                    end
                    // A zero divisor needs no special case: every trial subtract
                    // succeeds, giving all-ones quotient and remainder = A.
                    if (cnt == '0) begin
                        state    <= DONE;
                        done_q   <= 1'b1;
                        ready_q  <= 1'b1;
                        aluout_q <= is_div ? {rem_nxt, quo_nxt} : acc_nxt;
                        div0_q   <= is_div && (divisor == '0);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu at WIDTH=8 with a second WIDTH=16 instance.
module tb_iter_alu;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    iter_alu_if #(.WIDTH(8))  b8 ();
    iter_alu_if #(.WIDTH(16)) b16 ();

    iter_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    iter_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op on the WIDTH=8 instance; returns done latency and ready-low cycle count.
    task automatic run8(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int rdy_low);
        @(negedge clk);
        b8.start = 1'b1; b8.ALUFuncSel = sel; b8.regoutA = a; b8.regoutB = b;
        @(posedge clk);
        #1 b8.start = 1'b0;
        lat = 0; rdy_low = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!b8.ready) rdy_low++;
            if (b8.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run16(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
        @(negedge clk);
        b16.start = 1'b1; b16.ALUFuncSel = sel; b16.regoutA = a; b16.regoutB = b;
        @(posedge clk);
        #1 b16.start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (b16.done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int rl;
        int dcnt;
        logic [15:0] got;

        vectors = 0; miscompares = 0;
        rst_n = 1'b0;
        b8.start = 1'b0;  b8.ALUFuncSel = 2'b00;  b8.regoutA = '0;  b8.regoutB = '0;
        b16.start = 1'b0; b16.ALUFuncSel = 2'b00; b16.regoutA = '0; b16.regoutB = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_aluout", 32'(b8.aluout), 32'h0);
        check("rst_done",   32'(b8.done),   32'h0);
        check("rst_div0",   32'(b8.div0),   32'h0);
        check("rst_ready",  32'(b8.ready),  32'h1);

        run8(2'b00, 8'd200, 8'd150, lat, rl);
        check("mul_lat",    32'(lat), 32'd9);
        check("mul_rdylow", 32'(rl),  32'd8);
        check("mul_res",    32'(b8.aluout), 32'h7530);
        check("mul_div0",   32'(b8.div0), 32'h0);
        @(negedge clk);
        check("mul_done_pulse", 32'(b8.done), 32'h0);

        run8(2'b01, 8'd200, 8'd7, lat, rl);
        check("div_lat",  32'(lat), 32'd9);
        check("div_res",  32'(b8.aluout), 32'h041C);
        check("div_div0", 32'(b8.div0), 32'h0);

        run8(2'b01, 8'd37, 8'd0, lat, rl);
        check("div0_lat",  32'(lat), 32'd9);
        check("div0_res",  32'(b8.aluout), 32'h25FF);
        check("div0_flag", 32'(b8.div0), 32'h1);

        run8(2'b11, 8'd255, 8'd255, lat, rl);
        check("add_lat",  32'(lat), 32'd1);
        check("add_res",  32'(b8.aluout), 32'h01FE);
        check("add_div0", 32'(b8.div0), 32'h0);

        run8(2'b10, 8'd5, 8'd9, lat, rl);
        check("sub_lat", 32'(lat), 32'd1);
        check("sub_res", 32'(b8.aluout), 32'hFFFC);

        // Back-to-back add then sub, start held across two edges.
        @(negedge clk);
        b8.start = 1'b1; b8.ALUFuncSel = 2'b11; b8.regoutA = 8'd3; b8.regoutB = 8'd4;
        @(posedge clk);
        #1 b8.ALUFuncSel = 2'b10; b8.regoutA = 8'd2; b8.regoutB = 8'd3;
        @(negedge clk);
        check("b2b_done1", 32'(b8.done), 32'h1);
        check("b2b_add",   32'(b8.aluout), 32'h0007);
        check("b2b_ready", 32'(b8.ready), 32'h1);
        @(posedge clk);
        #1 b8.start = 1'b0;
        @(negedge clk);
        check("b2b_done2", 32'(b8.done), 32'h1);
        check("b2b_sub",   32'(b8.aluout), 32'hFFFF);
        @(negedge clk);
        check("b2b_idle",  32'(b8.done), 32'h0);

        // Start pulsed with new operands during a mul RUN must be ignored.
        @(negedge clk);
        b8.start = 1'b1; b8.ALUFuncSel = 2'b00; b8.regoutA = 8'd12; b8.regoutB = 8'd11;
        @(posedge clk);
        #1 b8.start = 1'b0;
        @(negedge clk);
        check("run_hold",  32'(b8.aluout), 32'hFFFF);
        check("run_ready", 32'(b8.ready), 32'h0);
        b8.start = 1'b1; b8.ALUFuncSel = 2'b11; b8.regoutA = 8'd1; b8.regoutB = 8'd1;
        @(posedge clk);
        #1 b8.start = 1'b0; b8.ALUFuncSel = 2'b01; b8.regoutA = 8'd99; b8.regoutB = 8'd99;
        dcnt = 0; got = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b8.done) begin
                dcnt++;
                got = b8.aluout;
            end
        end
        check("ign_done_cnt", 32'(dcnt), 32'd1);
        check("ign_res",      32'(got), 32'h0084);
        check("ign_hold",     32'(b8.aluout), 32'h0084);

        // Reset in the middle of a divide.
        @(negedge clk);
        b8.start = 1'b1; b8.ALUFuncSel = 2'b01; b8.regoutA = 8'd200; b8.regoutB = 8'd7;
        @(posedge clk);
        #1 b8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mrst_aluout", 32'(b8.aluout), 32'h0);
        check("mrst_ready",  32'(b8.ready), 32'h1);
        check("mrst_div0",   32'(b8.div0), 32'h0);
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (b8.done) dcnt++;
        end
        check("mrst_nodone", 32'(dcnt), 32'd0);
        run8(2'b11, 8'd100, 8'd50, lat, rl);
        check("mrst_add_lat", 32'(lat), 32'd1);
        check("mrst_add_res", 32'(b8.aluout), 32'h0096);

        // WIDTH=16 instance.
        run16(2'b00, 16'hFFFF, 16'hFFFF, lat);
        check("w16_mul_lat", 32'(lat), 32'd17);
        check("w16_mul_res", b16.aluout, 32'hFFFE0001);
        run16(2'b01, 16'd50000, 16'd300, lat);
        check("w16_div_lat", 32'(lat), 32'd17);
        check("w16_div_res", b16.aluout, 32'h00C800A6);
        check("w16_div0",    32'(b16.div0), 32'h0);
        run16(2'b10, 16'd1, 16'd2, lat);
        check("w16_sub_res", b16.aluout, 32'hFFFFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
